// File: rtl/imem_pkg.sv
// ============================================================================
// Module  : imem_pkg
// Summary : Shared widths and bank-occupancy encoding for the ping-pong imem.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package imem_pkg;

    localparam int IMEM_AW = 6;
    localparam int IMEM_DW = 6;

    typedef logic [1:0] occ_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_TWO   = 2'd2;

    // Number of banks currently holding a committed frame.
    function automatic occ_t occupancy(input logic [1:0] full);
        return occ_t'(full[0]) + occ_t'(full[1]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/imem_bank.sv
// ============================================================================
// Module  : imem_bank
// Summary : 2**AW x DW array, synchronous write, registered read.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_bank #(
    parameter int AW = 6,
    parameter int DW = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    // Kept under this name so hierarchical preloads can reach it.
    logic [DW-1:0] memblock [0:(1<<AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (i_we) begin
            memblock[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= memblock[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/imem_pingpong.sv
// ============================================================================
// Module  : imem_pingpong
// Summary : Double-buffered input memory; host fills one bank while the
//           engine reads the other, handed over by commit/release pulses.
// Build   : define IMEM_ERR_EN to build the sticky protocol-error flag.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module imem_pingpong
    import imem_pkg::*;
#(
    parameter int AW = IMEM_AW,
    parameter int DW = IMEM_DW
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          wr,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          commit,
    output logic          host_ready,
    input  logic [AW-1:0] oaddr,
    input  logic          rd,
    output logic [DW-1:0] odata,
    output logic          avail,
    input  logic          eng_release,   // engine done with the active bank
    output logic          err
);

    logic [1:0]    r_full;
    logic [1:0]    w_full_nxt;
    logic          r_fill_sel;
    logic          w_fill_sel_nxt;
    logic          r_act_sel;
    logic          w_act_sel_nxt;
    logic          r_rd_sel;
    logic          w_write_ok;
    logic          w_commit_ok;
    logic          w_read_ok;
    logic          w_release_ok;
    logic [DW-1:0] w_rdata0;
    logic [DW-1:0] w_rdata1;

    assign host_ready   = !r_full[r_fill_sel];
    assign avail        = r_full[r_act_sel];

    assign w_write_ok   = wr && host_ready;
    assign w_commit_ok  = commit && host_ready;
    assign w_read_ok    = rd && avail;
    assign w_release_ok = eng_release && avail;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_full     <= 2'b00;
            r_fill_sel <= 1'b0;
            r_act_sel  <= 1'b0;
            r_rd_sel   <= 1'b0;
        end else begin
            r_full     <= w_full_nxt;
            r_fill_sel <= w_fill_sel_nxt;
            r_act_sel  <= w_act_sel_nxt;
            // Remember which bank produced the read so a same-cycle release
            // cannot redirect the output mux.
            if (w_read_ok) begin
                r_rd_sel <= r_act_sel;
            end
        end
    end

    // Commit and release always address different banks, so both may apply.
    always_comb begin
        w_full_nxt     = r_full;
        w_fill_sel_nxt = r_fill_sel;
        w_act_sel_nxt  = r_act_sel;
        if (w_commit_ok) begin
            w_full_nxt[r_fill_sel] = 1'b1;
            w_fill_sel_nxt         = !r_fill_sel;
        end
        if (w_release_ok) begin
            w_full_nxt[r_act_sel] = 1'b0;
            w_act_sel_nxt         = !r_act_sel;
        end
    end

    imem_bank #(
        .AW (AW),
        .DW (DW)
    ) bank0 (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_write_ok && !r_fill_sel),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_re    (w_read_ok && !r_act_sel),
        .i_raddr (oaddr),
        .o_rdata (w_rdata0)
    );

    imem_bank #(
        .AW (AW),
        .DW (DW)
    ) bank1 (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_write_ok && r_fill_sel),
        .i_waddr (waddr),
        .i_wdata (wdata),
        .i_re    (w_read_ok && r_act_sel),
        .i_raddr (oaddr),
        .o_rdata (w_rdata1)
    );

    assign odata = r_rd_sel ? w_rdata1 : w_rdata0;

`ifdef IMEM_ERR_EN
    logic r_err;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (((wr || commit) && !host_ready) ||
                     ((eng_release || rd) && !avail)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_pingpong.sv
// ============================================================================
// Module  : tb_imem_pingpong
// Summary : Self-checking bench for imem_pingpong against a frame-queue model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_imem_pingpong;
    import imem_pkg::*;

    localparam int AW    = IMEM_AW;
    localparam int DW    = IMEM_DW;
    localparam int DEPTH = 1 << AW;
`ifdef IMEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          wr = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic          commit = 1'b0;
    logic          host_ready;
    logic [AW-1:0] oaddr = '0;
    logic          rd = 1'b0;
    logic [DW-1:0] odata;
    logic          avail;
    logic          eng_release = 1'b0;
    logic          err;

    int checks = 0;
    int errors = 0;

    // Reference model: bank contents plus a FIFO of committed bank ids.
    logic [DW-1:0] m_mem [2][DEPTH];
    int            m_q[$];
    int            m_fill = 0;
    logic [DW-1:0] m_odata = '0;
    logic          m_err = 1'b0;

    imem_pingpong dut (
        .clock       (clock),
        .reset       (reset),
        .wr          (wr),
        .waddr       (waddr),
        .wdata       (wdata),
        .commit      (commit),
        .host_ready  (host_ready),
        .oaddr       (oaddr),
        .rd          (rd),
        .odata       (odata),
        .avail       (avail),
        .eng_release (eng_release),
        .err         (err)
    );

    always #5 clock = ~clock;

    function automatic logic m_hr();
        return m_q.size() < 2;
    endfunction

    function automatic logic m_av();
        return m_q.size() > 0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_fill  = 0;
        m_odata = '0;
        m_err   = 1'b0;
    endtask

    task automatic model_step();
        logic hr;
        logic av;
        hr = m_hr();
        av = m_av();
        if (ERR_EN && (((wr || commit) && !hr) || ((eng_release || rd) && !av))) m_err = 1'b1;
        if (rd && av) m_odata = m_mem[m_q[0]][oaddr];
        if (wr && hr) m_mem[m_fill][waddr] = wdata;
        if (eng_release && av) void'(m_q.pop_front());
        if (commit && hr) begin
            m_q.push_back(m_fill);
            m_fill = 1 - m_fill;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic idle();
        wr = 1'b0; commit = 1'b0; rd = 1'b0; eng_release = 1'b0;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        model_reset();
        #1;
        checks++; if (host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready: got %b expected 1", host_ready); end
        checks++; if (avail !== 1'b0) begin errors++; $display("FAIL reset_avail: got %b expected 0", avail); end
        checks++; if (odata !== '0) begin errors++; $display("FAIL reset_odata: got %h expected 0", odata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        tick();
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (host_ready !== 1'b1 || avail !== 1'b0) begin errors++; $display("FAIL idle_flags: got hr=%b av=%b expected hr=1 av=0", host_ready, avail); end
    endtask

    // Load every word of both banks; the last write shares its cycle with commit.
    task automatic test_fill_all();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < DEPTH; a++) begin
                wr = 1'b1; waddr = AW'(a); wdata = DW'($urandom);
                commit = (a == DEPTH - 1);
                tick();
            end
            idle();
        end
        checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL fill_two_host_ready: got %b expected 0", host_ready); end
        checks++; if (avail !== 1'b1) begin errors++; $display("FAIL fill_two_avail: got %b expected 1", avail); end
        rd = 1'b1; oaddr = AW'(DEPTH - 1);
        tick(); idle();
        checks++; if (odata !== m_mem[0][DEPTH-1]) begin errors++; $display("FAIL fill_commit_write: got %h expected %h", odata, m_mem[0][DEPTH-1]); end
        eng_release = 1'b1;
        repeat (2) tick();
        idle();
        checks++; if (avail !== 1'b0 || host_ready !== 1'b1) begin errors++; $display("FAIL fill_drained: got av=%b hr=%b expected av=0 hr=1", avail, host_ready); end
    endtask

    task automatic test_single();
        wr = 1'b1; waddr = 6'd3; wdata = 6'h15;
        tick();
        wr = 1'b0; commit = 1'b1;
        tick(); idle();
        checks++; if (avail !== 1'b1) begin errors++; $display("FAIL single_avail: got %b expected 1", avail); end
        rd = 1'b1; oaddr = 6'd3;
        tick(); idle();
        checks++; if (odata !== 6'h15) begin errors++; $display("FAIL single_read: got %h expected 15", odata); end
        eng_release = 1'b1;
        tick(); idle();
        rd = 1'b1; oaddr = 6'd7;
        tick(); idle();
        checks++; if (odata !== 6'h15) begin errors++; $display("FAIL single_read_hold: got %h expected 15", odata); end
    endtask

    task automatic test_two_frames(output logic [5:0] va);
        va = {1'b0, 5'($urandom)};
        wr = 1'b1; waddr = 6'd3; wdata = va; commit = 1'b1;
        tick();
        wdata = 6'h2A;
        tick(); idle();
        checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL two_host_ready: got %b expected 0", host_ready); end
        rd = 1'b1; oaddr = 6'd3; eng_release = 1'b1;
        tick(); idle();
        checks++; if (odata !== va) begin errors++; $display("FAIL two_read_a: got %h expected %h", odata, va); end
        rd = 1'b1;
        tick(); idle();
        checks++; if (odata !== 6'h2A) begin errors++; $display("FAIL two_read_b: got %h expected 2a", odata); end
    endtask

    task automatic test_commit_release(output logic [5:0] vc);
        vc = {1'b1, 5'($urandom)} ^ 6'h0A;
        wr = 1'b1; waddr = 6'd3; wdata = vc;
        tick();
        wr = 1'b0; commit = 1'b1; eng_release = 1'b1;
        tick(); idle();
        checks++; if (avail !== 1'b1 || host_ready !== 1'b1) begin errors++; $display("FAIL swap_flags: got av=%b hr=%b expected av=1 hr=1", avail, host_ready); end
        rd = 1'b1; oaddr = 6'd3;
        tick(); idle();
        checks++; if (odata !== vc) begin errors++; $display("FAIL swap_read: got %h expected %h", odata, vc); end
    endtask

    task automatic test_full_write(input logic [5:0] vc);
        logic [5:0] vd;
        vd = 6'h3F ^ {3'b001, 3'($urandom)};
        wr = 1'b1; waddr = 6'd3; wdata = vd; commit = 1'b1;
        tick(); idle();
        wr = 1'b1; waddr = 6'd3; wdata = 6'h3F;
        tick(); idle();
        checks++; if (host_ready !== 1'b0) begin errors++; $display("FAIL full_host_ready: got %b expected 0", host_ready); end
        checks++; if (err !== ERR_EN) begin errors++; $display("FAIL full_err: got %b expected %b", err, ERR_EN); end
        rd = 1'b1; oaddr = 6'd3; eng_release = 1'b1;
        tick(); idle();
        checks++; if (odata !== vc) begin errors++; $display("FAIL full_bank_a: got %h expected %h", odata, vc); end
        rd = 1'b1; eng_release = 1'b1;
        tick(); idle();
        checks++; if (odata !== vd) begin errors++; $display("FAIL full_bank_b: got %h expected %h", odata, vd); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            wr          = ($urandom_range(0, 1) == 1);
            waddr       = AW'($urandom);
            wdata       = DW'($urandom);
            commit      = ($urandom_range(0, 5) == 0);
            rd          = ($urandom_range(0, 1) == 1);
            oaddr       = AW'($urandom);
            eng_release = ($urandom_range(0, 5) == 0);
            tick();
            checks++; if (host_ready !== m_hr()) begin errors++; $display("FAIL rand_host_ready[%0d]: got %b expected %b", i, host_ready, m_hr()); end
            checks++; if (avail !== m_av()) begin errors++; $display("FAIL rand_avail[%0d]: got %b expected %b", i, avail, m_av()); end
            checks++; if (odata !== m_odata) begin errors++; $display("FAIL rand_odata[%0d]: got %h expected %h", i, odata, m_odata); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rand_err[%0d]: got %b expected %b", i, err, m_err); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2 && m_av(); k++) begin
            eng_release = 1'b1;
            tick();
        end
        idle();
        wr = 1'b1; waddr = 6'd5; wdata = 6'h2B; commit = 1'b1;
        tick(); idle();
        rd = 1'b1; oaddr = 6'd5;
        tick();
        checks++; if (odata !== 6'h2B) begin errors++; $display("FAIL mid_pre_read: got %h expected 2b", odata); end
        #2 reset = 1'b0; rd = 1'b0;
        model_reset();
        #1;
        checks++; if (odata !== '0) begin errors++; $display("FAIL mid_odata: got %h expected 0", odata); end
        checks++; if (avail !== 1'b0 || host_ready !== 1'b1) begin errors++; $display("FAIL mid_flags: got av=%b hr=%b expected av=0 hr=1", avail, host_ready); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err); end
        tick();
        reset = 1'b1;
        tick();
        checks++; if (avail !== 1'b0 || host_ready !== 1'b1) begin errors++; $display("FAIL post_reset_flags: got av=%b hr=%b expected av=0 hr=1", avail, host_ready); end
    endtask

    initial begin
        logic [5:0] va;
        logic [5:0] vc;
        test_reset();
        test_fill_all();
        test_single();
        test_two_frames(va);
        test_commit_release(vc);
        test_full_write(vc);
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
